id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_ex_stage_operand_mux.sv | 43 ++++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX pipeline stage: forwarding select
// encodings, control-bit bundle and small helpers.
package id_ex_stage_pkg;

  localparam int ALUOP_W = 4;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_WB     = 2'b01,
    FWD_MEM    = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic reg_wrt;
    logic mem_rd;
    logic mem_wrt;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_mux.sv
// EX operand selection: forwarding muxes for both sources plus the
// immediate/register choice for operand B.
module ex_operand_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [1:0]      src_a,
  input  logic [1:0]      src_b,
  input  logic [XLEN-1:0] alu_res_mem,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] store_data
);

  function automatic logic [XLEN-1:0] fwd_pick(input logic [1:0]      sel,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] mem,
                                               input logic [XLEN-1:0] wb);
    case (fwd_sel_e'(sel))
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  assign fwd_a = fwd_pick(src_a, rs1_data, alu_res_mem, wb_data);
  assign fwd_b = fwd_pick(src_b, rs2_data, alu_res_mem, wb_data);

  assign op_a       = fwd_a;
  assign op_b       = alu_src ? imm : fwd_b;
  // Stores always need the forwarded rs2 value, even when B takes the immediate.
  assign store_data = fwd_b;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control,
// a saturating bubble counter and forwarded EX operands.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_id,
  input  logic [XLEN-1:0]    pc_id,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [XLEN-1:0]    imm_id,
  input  logic [REG_W-1:0]   rs1_id,
  input  logic [REG_W-1:0]   rs2_id,
  input  logic [REG_W-1:0]   rdst_id,
  input  logic               regWrt_id,
  input  logic               memRd_id,
  input  logic               memWrt_id,
  input  logic               memToReg_id,
  input  logic               aluSrc_id,
  input  logic [ALUOP_W-1:0] aluOp_id,
  input  logic               flush_ex,
  input  logic               hold_ex,
  input  logic [1:0]         srcA,
  input  logic [1:0]         srcB,
  input  logic [XLEN-1:0]    aluRes_EX_MEM,
  input  logic [XLEN-1:0]    wbData_MEM_WB,
  output logic               valid_ex,
  output logic [XLEN-1:0]    pc_ex,
  output logic [REG_W-1:0]   rs1_ex,
  output logic [REG_W-1:0]   rs2_ex,
  output logic [REG_W-1:0]   rdst_ex,
  output logic               regWrt_ex,
  output logic               memRd_ex,
  output logic               memWrt_ex,
  output logic               memToReg_ex,
  output logic [ALUOP_W-1:0] aluOp_ex,
  output logic [XLEN-1:0]    opA,
  output logic [XLEN-1:0]    opB,
  output logic [XLEN-1:0]    storeData,
  output logic               loadUse_stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               valid;
    ctrl_t              ctrl;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rdst;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
  } entry_t;

  entry_t           entry_q, entry_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  ctrl_t            ctrl_id;
  logic             load_use;
  logic             insert_bubble;

  // An invalid ID slot must never carry live control into EX.
  assign ctrl_id = {regWrt_id, memRd_id, memWrt_id, memToReg_id, aluSrc_id} & {5{valid_id}};

  // x0 is hardwired, so a load targeting it can never create a hazard.
  assign load_use = entry_q.valid && entry_q.ctrl.mem_rd && (entry_q.rdst != '0) &&
                    ((entry_q.rdst == rs1_id) || (entry_q.rdst == rs2_id)) && valid_id;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    entry_d       = entry_q;
    bubble_cnt_d  = bubble_cnt_q;
    insert_bubble = 1'b0;
    if (flush_ex) begin
      insert_bubble = 1'b1;
    end else if (!hold_ex) begin
      if (load_use) begin
        insert_bubble = 1'b1;
      end else begin
        entry_d.valid    = valid_id;
        entry_d.ctrl     = ctrl_id;
        entry_d.alu_op   = aluOp_id;
        entry_d.rs1      = rs1_id;
        entry_d.rs2      = rs2_id;
        entry_d.rdst     = rdst_id;
        entry_d.pc       = pc_id;
        entry_d.rs1_data = rs1_data;
        entry_d.rs2_data = rs2_data;
        entry_d.imm      = imm_id;
      end
    end
    if (insert_bubble) begin
      entry_d      = '0;
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      entry_q      <= entry_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_ex      = entry_q.valid;
  assign pc_ex         = entry_q.pc;
  assign rs1_ex        = entry_q.rs1;
  assign rs2_ex        = entry_q.rs2;
  assign rdst_ex       = entry_q.rdst;
  assign regWrt_ex     = entry_q.ctrl.reg_wrt;
  assign memRd_ex      = entry_q.ctrl.mem_rd;
  assign memWrt_ex     = entry_q.ctrl.mem_wrt;
  assign memToReg_ex   = entry_q.ctrl.mem_to_reg;
  assign aluOp_ex      = entry_q.alu_op;
  assign loadUse_stall = load_use;
  assign bubble_cnt    = bubble_cnt_q;

  ex_operand_mux #(.XLEN(XLEN)) u_operand_mux (
    .rs1_data    (entry_q.rs1_data),
    .rs2_data    (entry_q.rs2_data),
    .imm         (entry_q.imm),
    .alu_src     (entry_q.ctrl.alu_src),
    .src_a       (srcA),
    .src_b       (srcB),
    .alu_res_mem (aluRes_EX_MEM),
    .wb_data     (wbData_MEM_WB),
    .op_a        (opA),
    .op_b        (opB),
    .store_data  (storeData)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model queues the expected
// ID/EX contents each cycle; they are popped and compared after the edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               valid_id;
  logic [XLEN-1:0]    pc_id, rs1_data, rs2_data, imm_id;
  logic [4:0]         rs1_id, rs2_id, rdst_id;
  logic               regWrt_id, memRd_id, memWrt_id, memToReg_id, aluSrc_id;
  logic [3:0]         aluOp_id;
  logic               flush_ex, hold_ex;
  logic [1:0]         srcA, srcB;
  logic [XLEN-1:0]    aluRes_EX_MEM, wbData_MEM_WB;
  logic               valid_ex;
  logic [XLEN-1:0]    pc_ex;
  logic [4:0]         rs1_ex, rs2_ex, rdst_ex;
  logic               regWrt_ex, memRd_ex, memWrt_ex, memToReg_ex;
  logic [3:0]         aluOp_ex;
  logic [XLEN-1:0]    opA, opB, storeData;
  logic               loadUse_stall;
  logic [15:0]        bubble_cnt;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rdst_id(rdst_id),
    .regWrt_id(regWrt_id), .memRd_id(memRd_id), .memWrt_id(memWrt_id),
    .memToReg_id(memToReg_id), .aluSrc_id(aluSrc_id), .aluOp_id(aluOp_id),
    .flush_ex(flush_ex), .hold_ex(hold_ex), .srcA(srcA), .srcB(srcB),
    .aluRes_EX_MEM(aluRes_EX_MEM), .wbData_MEM_WB(wbData_MEM_WB),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rdst_ex(rdst_ex), .regWrt_ex(regWrt_ex), .memRd_ex(memRd_ex),
    .memWrt_ex(memWrt_ex), .memToReg_ex(memToReg_ex), .aluOp_ex(aluOp_ex),
    .opA(opA), .opB(opB), .storeData(storeData),
    .loadUse_stall(loadUse_stall), .bubble_cnt(bubble_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the ID/EX register.
  logic            m_valid, m_rw, m_mr, m_mw, m_m2r, m_as;
  logic [XLEN-1:0] m_pc, m_r1d, m_r2d, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rdst;
  logic [3:0]      m_aop;
  logic [15:0]     m_cnt;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rdst;
    logic [3:0]  ctrl;
    logic [3:0]  aop;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  function automatic logic model_stall();
    return m_valid && m_mr && (m_rdst != 5'd0) &&
           ((m_rdst == rs1_id) || (m_rdst == rs2_id)) && valid_id;
  endfunction

  function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] rf);
    if (sel == 2'b01) return wbData_MEM_WB;
    if (sel == 2'b10) return aluRes_EX_MEM;
    return rf;
  endfunction

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_as} = '0;
    {m_pc, m_r1d, m_r2d, m_imm} = '0;
    {m_rs1, m_rs2, m_rdst, m_aop} = '0;
    m_cnt = '0;
  endtask

  task automatic model_bubble();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_as} = '0;
    {m_rs1, m_rs2, m_rdst} = '0;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic model_load();
    m_valid = valid_id;
    m_rw  = valid_id & regWrt_id;
    m_mr  = valid_id & memRd_id;
    m_mw  = valid_id & memWrt_id;
    m_m2r = valid_id & memToReg_id;
    m_as  = valid_id & aluSrc_id;
    m_aop = aluOp_id;
    m_pc  = pc_id;
    m_rs1 = rs1_id; m_rs2 = rs2_id; m_rdst = rdst_id;
    m_r1d = rs1_data; m_r2d = rs2_data; m_imm = imm_id;
  endtask

  task automatic check_comb();
    check("load_use_stall", loadUse_stall, model_stall());
    if (m_valid) begin
      check("op_a", opA, fwd(srcA, m_r1d));
      check("op_b", opB, m_as ? m_imm : fwd(srcB, m_r2d));
      check("store_data", storeData, fwd(srcB, m_r2d));
    end
  endtask

  // Called at a negedge after inputs are driven; returns at the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    check_comb();
    if (flush_ex) model_bubble();
    else if (!hold_ex) begin
      if (model_stall()) model_bubble();
      else model_load();
    end
    e.valid = m_valid; e.pc = m_pc; e.rs1 = m_rs1; e.rs2 = m_rs2; e.rdst = m_rdst;
    e.ctrl = {m_rw, m_mr, m_mw, m_m2r}; e.aop = m_aop; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("valid_ex", valid_ex, e.valid);
    check("rs1_ex", rs1_ex, e.rs1);
    check("rs2_ex", rs2_ex, e.rs2);
    check("rdst_ex", rdst_ex, e.rdst);
    check("ctrl_ex", {regWrt_ex, memRd_ex, memWrt_ex, memToReg_ex}, e.ctrl);
    check("bubble_cnt", bubble_cnt, e.cnt);
    if (e.valid) begin
      check("pc_ex", pc_ex, e.pc);
      check("alu_op_ex", aluOp_ex, e.aop);
    end
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1, r2, rd,
                        input logic rw, mr, mw, m2r, as, input logic [3:0] aop,
                        input logic [31:0] d1, d2, imm);
    valid_id = v; pc_id = pc; rs1_id = r1; rs2_id = r2; rdst_id = rd;
    regWrt_id = rw; memRd_id = mr; memWrt_id = mw; memToReg_id = m2r; aluSrc_id = as;
    aluOp_id = aop; rs1_data = d1; rs2_data = d2; imm_id = imm;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush_ex = 0; hold_ex = 0; srcA = 0; srcB = 0;
    aluRes_EX_MEM = 0; wbData_MEM_WB = 0;
    model_reset();
    #1;
    check("rst_valid_ex", valid_ex, 1'b0);
    check("rst_pc_ex", pc_ex, 32'h0);
    check("rst_bubble_cnt", bubble_cnt, 16'h0);
    check("rst_load_use", loadUse_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5,4(x2) then add x6,x5,x1
    set_id(1, 32'h100, 5'd2, 5'd0, 5'd5, 1, 1, 0, 1, 1, 4'h0, 32'h1000, 0, 32'h4);
    cycle();
    set_id(1, 32'h104, 5'd5, 5'd1, 5'd6, 1, 0, 0, 0, 0, 4'h2, 32'h11, 32'h22, 0);
    #1 check("lu_add_stall", loadUse_stall, 1'b1);
    cycle();
    check("lu_bubble_valid", valid_ex, 1'b0);
    check("lu_bubble_cnt", bubble_cnt, 16'd1);
    cycle();
    check("lu_add_pc", pc_ex, 32'h104);
    check("lu_add_stall_clear", loadUse_stall, 1'b0);

    // Operand A forwarding with the add in EX.
    aluRes_EX_MEM = 32'hAA; wbData_MEM_WB = 32'hBB;
    srcA = 2'b10; #1 check("fwd_a_mem", opA, 32'hAA);
    srcA = 2'b01; #1 check("fwd_a_wb", opA, 32'hBB);
    srcA = 2'b11; #1 check("fwd_a_rf", opA, 32'h11);
    srcA = 2'b00;
    @(negedge clk);

    // sw x6,8(x2): immediate on B, forwarded rs2 on store data.
    set_id(1, 32'h108, 5'd2, 5'd6, 5'd0, 0, 0, 1, 0, 1, 4'h0, 32'h2000, 32'h33, 32'h8);
    cycle();
    srcB = 2'b10; aluRes_EX_MEM = 32'h55;
    #1 check("sw_op_b", opB, 32'h8);
    check("sw_store_data", storeData, 32'h55);
    srcB = 2'b00;
    @(negedge clk);

    // Hold three cycles while ID changes underneath.
    hold_ex = 1;
    set_id(1, 32'hDEAD, 5'd9, 5'd9, 5'd9, 1, 1, 0, 1, 0, 4'hF, 1, 2, 3);
    for (int i = 0; i < 3; i++) cycle();
    check("hold_pc_ex", pc_ex, 32'h108);
    check("hold_mem_wrt", memWrt_ex, 1'b1);
    hold_ex = 0;

    // lw x7, then flush with hold and a live load-use.
    set_id(1, 32'h10C, 5'd2, 5'd0, 5'd7, 1, 1, 0, 1, 1, 4'h0, 0, 0, 32'h10);
    cycle();
    set_id(1, 32'h110, 5'd7, 5'd3, 5'd8, 1, 0, 0, 0, 0, 4'h1, 0, 0, 0);
    flush_ex = 1; hold_ex = 1;
    #1 check("flush_lu_active", loadUse_stall, 1'b1);
    cycle();
    check("flush_valid", valid_ex, 1'b0);
    check("flush_reg_wrt", regWrt_ex, 1'b0);
    check("flush_bubble_cnt", bubble_cnt, 16'd2);
    flush_ex = 0; hold_ex = 0;

    // lw x0 followed by a use of x0 never stalls.
    set_id(1, 32'h114, 5'd2, 5'd0, 5'd0, 1, 1, 0, 1, 1, 4'h0, 0, 0, 0);
    cycle();
    set_id(1, 32'h118, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    #1 check("x0_no_stall", loadUse_stall, 1'b0);
    cycle();

    // Invalid ID slot carries no control.
    set_id(0, 32'h11C, 5'd1, 5'd2, 5'd9, 1, 1, 1, 1, 1, 4'h3, 0, 0, 0);
    cycle();
    check("inv_reg_wrt", regWrt_ex, 1'b0);
    check("inv_mem_rd", memRd_ex, 1'b0);

    // Random traffic with a small register range to provoke hazards.
    for (int i = 0; i < 60; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), $urandom, $urandom, $urandom);
      flush_ex = ($urandom_range(0, 9) == 0);
      hold_ex  = ($urandom_range(0, 5) == 0);
      srcA = 2'($urandom); srcB = 2'($urandom);
      aluRes_EX_MEM = $urandom; wbData_MEM_WB = $urandom;
      cycle();
    end
    flush_ex = 0; hold_ex = 0;

    // Async reset mid-stall, between clock edges.
    set_id(1, 32'h200, 5'd2, 5'd0, 5'd4, 1, 1, 0, 1, 1, 4'h0, 0, 0, 0);
    cycle();
    hold_ex = 1;
    set_id(1, 32'h204, 5'd4, 5'd0, 5'd5, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_ex", valid_ex, 1'b0);
    check("arst_pc_ex", pc_ex, 32'h0);
    check("arst_reg_wrt", regWrt_ex, 1'b0);
    check("arst_bubble_cnt", bubble_cnt, 16'h0);
    check("arst_load_use", loadUse_stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; hold_ex = 0;
    cycle();
    check("post_rst_pc", pc_ex, 32'h204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
